// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: programmable half-period, CPOL/CPHA and burst length,
// with shift/sample strobes for the shifter and a start/busy/done/abort handshake.
module spi_sclk_gen #(
    parameter int   DIV_W      = 8,
    parameter int   CNT_W      = 6,
    parameter logic RESET_CPOL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             cpol_i,
    input  logic             cpha_i,
    input  logic [CNT_W-1:0] nbits_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sclk_o,
    output logic             shift_o,
    output logic             sample_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t           state_r;
    logic [DIV_W-1:0] cnt_r;
    logic [CNT_W:0]   edge_r;
    logic [DIV_W-1:0] div_r;
    logic             cpol_r;
    logic             cpha_r;
    logic [CNT_W-1:0] nbits_r;
    logic             busy_r;
    logic             done_r;
    logic             sclk_r;
    logic             shift_r;
    logic             sample_r;

    logic [CNT_W:0]   edge_nxt_s;
    logic             cnt_zero_s;
    logic             last_edge_s;
    logic             shift_edge_s;
    logic             sample_edge_s;

    // Edge bookkeeping: which strobe the upcoming SCLK edge carries.
    always_comb begin
        edge_nxt_s    = edge_r + {{CNT_W{1'b0}}, 1'b1};
        cnt_zero_s    = (cnt_r == {DIV_W{1'b0}});
        last_edge_s   = (edge_nxt_s == {nbits_r, 1'b0});
        shift_edge_s  = 1'b0;
        sample_edge_s = 1'b0;
        if (cpha_r) begin
            shift_edge_s  = edge_nxt_s[0];
            sample_edge_s = ~edge_nxt_s[0];
        end else begin
            // the last trailing edge has no following bit to launch
            sample_edge_s = edge_nxt_s[0];
            shift_edge_s  = ~edge_nxt_s[0] & ~last_edge_s;
        end
    end

    // Burst FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {DIV_W{1'b0}};
            edge_r   <= {(CNT_W+1){1'b0}};
            div_r    <= {DIV_W{1'b0}};
            cpol_r   <= RESET_CPOL;
            cpha_r   <= 1'b0;
            nbits_r  <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            sclk_r   <= RESET_CPOL;
            shift_r  <= 1'b0;
            sample_r <= 1'b0;
        end else begin
            done_r   <= 1'b0;
            shift_r  <= 1'b0;
            sample_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        if (nbits_i != {CNT_W{1'b0}}) begin
                            div_r   <= div_i;
                            cpol_r  <= cpol_i;
                            cpha_r  <= cpha_i;
                            nbits_r <= nbits_i;
                            cnt_r   <= div_i;
                            edge_r  <= {(CNT_W+1){1'b0}};
                            busy_r  <= 1'b1;
                            sclk_r  <= cpol_i;
                            shift_r <= ~cpha_i;
                            state_r <= RUN;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_i) begin
                        busy_r  <= 1'b0;
                        sclk_r  <= cpol_r;
                        state_r <= IDLE;
                    end else if (cnt_zero_s) begin
                        cnt_r    <= div_r;
                        sclk_r   <= ~sclk_r;
                        edge_r   <= edge_nxt_s;
                        shift_r  <= shift_edge_s;
                        sample_r <= sample_edge_s;
                        if (last_edge_s) begin
                            state_r <= TAIL;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                TAIL: begin
                    if (abort_i) begin
                        busy_r  <= 1'b0;
                        sclk_r  <= cpol_r;
                        state_r <= IDLE;
                    end else if (cnt_zero_s) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    sclk_r  <= cpol_r;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign sclk_o   = sclk_r;
    assign shift_o  = shift_r;
    assign sample_o = sample_r;

endmodule
